// File: rtl/osd_mam_wb_pkg.sv
// Shared state encoding, Wishbone cycle-type constants and segment helper
// for the MAM-to-Wishbone burst bridge.
package osd_mam_wb_pkg;

    localparam int CNT_W = 14;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_WR_BUS  = 3'd2,
        ST_RD_BUS  = 3'd3,
        ST_GAP     = 3'd4,
        ST_ERR     = 3'd5
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // Length of the next bus segment: whatever is left, capped at the burst limit.
    function automatic logic [CNT_W-1:0] seg_len(input logic [CNT_W-1:0] remaining,
                                                 input logic [CNT_W-1:0] max_burst);
        return (remaining > max_burst) ? max_burst : remaining;
    endfunction

endpackage

// File: rtl/osd_mam_rd_fifo.sv
// Registered synchronous FIFO with valid/ready ports; accepts a push while
// full when the head is popped in the same cycle.
module osd_mam_rd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    assign out_valid = (count_q != '0);
    assign in_ready  = (count_q != FULL_CNT) || out_ready;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: rtl/osd_mam_wb_burst_if.sv
// MAM request/write/read streams to Wishbone B3 classic and incrementing-burst
// master, splitting long requests into segments of at most MAX_BURST beats.
module osd_mam_wb_burst_if
    import osd_mam_wb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MAX_BURST     = 16,
    parameter int RD_FIFO_DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_rw,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_burst,
    input  logic [13:0]             req_beats,
    input  logic                    write_valid,
    output logic                    write_ready,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strb,
    output logic                    read_valid,
    input  logic                    read_ready,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    err_o,
    output logic                    cyc_o,
    output logic                    stb_o,
    output logic                    we_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic [DATA_WIDTH/8-1:0] sel_o,
    output logic [2:0]              cti_o,
    output logic [1:0]              bte_o,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic                    ack_i,
    input  logic                    err_i,
    output logic [2:0]              dbg_state_o
);

    // All MAM-side streams transfer exactly on a rising clk_i edge where
    // valid && ready; valid never waits on ready, ready is driven from flops.

    localparam int SEL_W   = DATA_WIDTH / 8;
    localparam int FIFO_CW = $clog2(RD_FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]      MAX_SEG   = CNT_W'(MAX_BURST);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(SEL_W);
    localparam logic [FIFO_CW-1:0]    FIFO_FULL = FIFO_CW'(RD_FIFO_DEPTH);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [CNT_W-1:0]        rem_q, rem_d;
    logic [CNT_W-1:0]        seg_q, seg_d;
    logic                    rw_q, rw_d;
    logic                    single_q, single_d;
    logic                    cyc_q, cyc_d;
    logic                    err_q, err_d;
    logic                    run_q;

    logic                    stb;
    logic                    bus_ack;
    logic                    bus_err;
    logic [CNT_W-1:0]        req_rem;
    logic                    fifo_push;
    logic                    fifo_push_ready;
    logic [DATA_WIDTH-1:0]   fifo_push_data;
    logic [FIFO_CW-1:0]      fifo_count;

    // Requests wait for the read FIFO to drain so responses never interleave.
    assign req_ready   = run_q && (state_q == ST_IDLE) && (fifo_count == '0);
    assign write_ready = (state_q == ST_WR_DATA) ||
                         ((state_q == ST_ERR) && rw_q && (rem_q != '0));
    assign stb         = (state_q == ST_WR_BUS) ||
                         ((state_q == ST_RD_BUS) && (fifo_count < FIFO_FULL));
    assign bus_err     = stb && err_i;
    assign bus_ack     = stb && ack_i && !err_i;
    assign req_rem     = !req_burst ? CNT_W'(1) :
                         ((req_beats == 14'd0) ? CNT_W'(1) : req_beats);

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        dat_d          = dat_q;
        sel_d          = sel_q;
        rem_d          = rem_q;
        seg_d          = seg_q;
        rw_d           = rw_q;
        single_d       = single_q;
        cyc_d          = cyc_q;
        err_d          = err_q;
        fifo_push      = 1'b0;
        fifo_push_data = dat_i;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d   = req_addr;
                    rw_d     = req_rw;
                    single_d = !req_burst;
                    rem_d    = req_rem;
                    seg_d    = seg_len(req_rem, MAX_SEG);
                    sel_d    = '1;
                    err_d    = 1'b0;
                    if (req_rw) begin
                        state_d = ST_WR_DATA;
                    end else begin
                        state_d = ST_RD_BUS;
                        cyc_d   = 1'b1;
                    end
                end
            end

            ST_WR_DATA: begin
                if (write_valid) begin
                    dat_d   = write_data;
                    sel_d   = single_q ? write_strb : '1;
                    cyc_d   = 1'b1;
                    state_d = ST_WR_BUS;
                end
            end

            ST_WR_BUS, ST_RD_BUS: begin
                fifo_push = bus_ack && !rw_q;
                if (bus_err) begin
                    // A failed write beat already consumed its data; a failed
                    // read beat is still owed to the MAM as a zero.
                    err_d   = 1'b1;
                    cyc_d   = 1'b0;
                    state_d = ST_ERR;
                    if (rw_q) begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end else if (bus_ack) begin
                    addr_d = addr_q + ADDR_STEP;
                    rem_d  = rem_q - CNT_W'(1);
                    seg_d  = seg_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        cyc_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else if (seg_q == CNT_W'(1)) begin
                        cyc_d   = 1'b0;
                        state_d = ST_GAP;
                    end else if (rw_q) begin
                        state_d = ST_WR_DATA;
                    end
                end
            end

            ST_GAP: begin
                seg_d = seg_len(rem_q, MAX_SEG);
                if (rw_q) begin
                    state_d = ST_WR_DATA;
                end else begin
                    cyc_d   = 1'b1;
                    state_d = ST_RD_BUS;
                end
            end

            ST_ERR: begin
                if (rem_q == '0) begin
                    state_d = ST_IDLE;
                end else if (rw_q) begin
                    if (write_valid) begin
                        rem_d = rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    fifo_push      = 1'b1;
                    fifo_push_data = '0;
                    if (fifo_push_ready) begin
                        rem_d = rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                cyc_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            dat_q    <= '0;
            sel_q    <= '1;
            rem_q    <= '0;
            seg_q    <= '0;
            rw_q     <= 1'b0;
            single_q <= 1'b0;
            cyc_q    <= 1'b0;
            err_q    <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            rem_q    <= rem_d;
            seg_q    <= seg_d;
            rw_q     <= rw_d;
            single_q <= single_d;
            cyc_q    <= cyc_d;
            err_q    <= err_d;
            run_q    <= 1'b1;
        end
    end

    osd_mam_rd_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_valid  (fifo_push),
        .in_ready  (fifo_push_ready),
        .in_data   (fifo_push_data),
        .out_valid (read_valid),
        .out_ready (read_ready),
        .out_data  (read_data),
        .count     (fifo_count)
    );

    assign cyc_o       = cyc_q;
    assign stb_o       = stb;
    assign we_o        = cyc_q && rw_q;
    assign addr_o      = addr_q;
    assign dat_o       = dat_q;
    assign sel_o       = sel_q;
    assign cti_o       = !cyc_q ? CTI_CLASSIC :
                         ((seg_q == CNT_W'(1)) ? CTI_END : CTI_INCR);
    assign bte_o       = BTE_LINEAR;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_osd_mam_wb_burst_if.sv
// Directed scoreboard bench: stimulus queues expected bus beats and read words,
// independent monitors pop and compare whenever the DUT presents them.
module tb_osd_mam_wb_burst_if;
    import osd_mam_wb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        logic [2:0]    cti;
    } beat_t;

    logic          clk_i, rst_ni;
    logic          req_valid, req_ready, req_rw, req_burst;
    logic [AW-1:0] req_addr;
    logic [13:0]   req_beats;
    logic          write_valid, write_ready;
    logic [DW-1:0] write_data;
    logic [SW-1:0] write_strb;
    logic          read_valid, read_ready;
    logic [DW-1:0] read_data;
    logic          err_o, cyc_o, stb_o, we_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] dat_o, dat_i;
    logic [SW-1:0] sel_o;
    logic [2:0]    cti_o;
    logic [1:0]    bte_o;
    logic          ack_i, err_i;
    logic [2:0]    dbg_state_o;

    beat_t         exp_bus_q[$];
    logic [DW-1:0] exp_rd_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            resp_cnt = 0;
    int            err_at = 0;
    int            bus_beats = 0;
    int            cyc_rises = 0;
    bit            ack_en = 1'b1;

    osd_mam_wb_burst_if #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(16), .RD_FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_burst(req_burst), .req_beats(req_beats),
        .write_valid(write_valid), .write_ready(write_ready),
        .write_data(write_data), .write_strb(write_strb),
        .read_valid(read_valid), .read_ready(read_ready), .read_data(read_data),
        .err_o(err_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .addr_o(addr_o), .dat_o(dat_o), .sel_o(sel_o), .cti_o(cti_o),
        .bte_o(bte_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_bus(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input logic [2:0] c);
        beat_t b;
        b.addr = a; b.we = we; b.dat = d; b.sel = s; b.cti = c;
        exp_bus_q.push_back(b);
    endtask

    // ---------------- Wishbone slave (drives at negedge+2) ----------------
    initial begin
        ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
        forever begin
            @(negedge clk_i); #2;
            if (stb_o && ack_en) begin
                resp_cnt++;
                err_i = (resp_cnt == err_at);
                ack_i = !err_i;
                dat_i = rd_pat(addr_o);
            end else begin
                ack_i = 1'b0;
                err_i = 1'b0;
            end
        end
    end

    // ---------------- bus beat monitor ----------------
    initial begin
        beat_t e, g;
        logic prev_cyc;
        prev_cyc = 1'b0;
        forever begin
            @(negedge clk_i); #3;
            if (cyc_o && !prev_cyc) cyc_rises++;
            prev_cyc = cyc_o;
            if (stb_o && ack_i) begin
                bus_beats++;
                if (exp_bus_q.size() == 0) begin
                    check("bus_beat_expected", 128'(0), 128'(1));
                end else begin
                    e = exp_bus_q.pop_front();
                    g.addr = addr_o; g.we = we_o; g.sel = sel_o; g.cti = cti_o;
                    g.dat = we_o ? dat_o : e.dat;
                    check("bus_beat", 128'(g), 128'(e));
                end
            end
        end
    end

    // ---------------- read data monitor ----------------
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk_i); #3;
            if (read_valid && read_ready) begin
                if (exp_rd_q.size() == 0) begin
                    check("read_expected", 128'(0), 128'(1));
                end else begin
                    e = exp_rd_q.pop_front();
                    check("read_data", 128'(read_data), 128'(e));
                end
            end
        end
    end

    // ---------------- driver tasks (called at negedge) ----------------
    task automatic send_req(input logic rw, input logic [AW-1:0] a, input logic burst,
                            input logic [13:0] beats);
        int n;
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_burst = burst; req_beats = beats;
        n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        check("req_accept", 128'(req_ready), 128'(1));
        @(negedge clk_i);
        req_valid = 1'b0;
    endtask

    task automatic send_write(input logic [DW-1:0] d, input logic [SW-1:0] s, input int gap);
        int n;
        write_valid = 1'b1; write_data = d; write_strb = s;
        n = 0;
        while (!write_ready && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        check("write_accept", 128'(write_ready), 128'(1));
        @(negedge clk_i);
        write_valid = 1'b0;
        repeat (gap) @(negedge clk_i);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_bus_q.size() != 0 || exp_rd_q.size() != 0 || read_valid ||
                dbg_state_o != ST_IDLE) && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        check("transfer_done", 128'(n < 2000), 128'(1));
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int n, b0, r0;
        rst_ni = 1'b0;
        req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_burst = 1'b0; req_beats = '0;
        write_valid = 1'b0; write_data = '0; write_strb = '0; read_ready = 1'b1;
        repeat (3) @(negedge clk_i);

        check("rst_cyc", 128'(cyc_o), 128'(0));
        check("rst_stb", 128'(stb_o), 128'(0));
        check("rst_we", 128'(we_o), 128'(0));
        check("rst_err", 128'(err_o), 128'(0));
        check("rst_addr", 128'(addr_o), 128'(0));
        check("rst_dat", 128'(dat_o), 128'(0));
        check("rst_cti", 128'(cti_o), 128'(3'b000));
        check("rst_sel", 128'(sel_o), 128'(4'hF));
        check("rst_bte", 128'(bte_o), 128'(2'b00));
        check("rst_req_ready", 128'(req_ready), 128'(0));
        check("rst_write_ready", 128'(write_ready), 128'(0));
        check("rst_read_valid", 128'(read_valid), 128'(0));
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        check("idle_req_ready", 128'(req_ready), 128'(1));

        // single write with byte strobes
        push_bus(32'h100, 1'b1, 32'hDEADBEEF, 4'b0011, 3'b111);
        send_req(1'b1, 32'h100, 1'b0, 14'd0);
        send_write(32'hDEADBEEF, 4'b0011, 0);
        wait_done();
        check("wr_single_err", 128'(err_o), 128'(0));

        // 40-beat read split 16/16/8
        for (int i = 0; i < 40; i++) begin
            push_bus(AW'(i * 4), 1'b0, '0, 4'hF,
                     ((i % 16) == 15 || i == 39) ? 3'b111 : 3'b010);
            exp_rd_q.push_back(rd_pat(AW'(i * 4)));
        end
        r0 = cyc_rises;
        send_req(1'b0, 32'h0, 1'b1, 14'd40);
        wait_done();
        check("rd40_segments", 128'(cyc_rises - r0), 128'(3));

        // 8-beat read with stalled consumer
        read_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_bus(32'h200 + AW'(i * 4), 1'b0, '0, 4'hF, (i == 7) ? 3'b111 : 3'b010);
            exp_rd_q.push_back(rd_pat(32'h200 + AW'(i * 4)));
        end
        b0 = bus_beats;
        send_req(1'b0, 32'h200, 1'b1, 14'd8);
        n = 0;
        while (bus_beats == b0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("rd8_first_ack", 128'(bus_beats != b0), 128'(1));
        repeat (6) @(negedge clk_i);
        check("rd8_full_stb", 128'(stb_o), 128'(0));
        check("rd8_full_cyc", 128'(cyc_o), 128'(1));
        check("rd8_full_beats", 128'(bus_beats - b0), 128'(4));
        repeat (3) @(negedge clk_i);
        read_ready = 1'b1;
        wait_done();

        // 5-beat write, data every other cycle
        for (int i = 0; i < 5; i++)
            push_bus(32'h300 + AW'(i * 4), 1'b1, 32'hA0A0_0000 + DW'(i), 4'hF,
                     (i == 4) ? 3'b111 : 3'b010);
        send_req(1'b1, 32'h300, 1'b1, 14'd5);
        for (int i = 0; i < 5; i++) send_write(32'hA0A0_0000 + DW'(i), 4'b0000, 1);
        wait_done();

        // bus error on beat 3 of a 6-beat read
        err_at = resp_cnt + 3;
        push_bus(32'h400, 1'b0, '0, 4'hF, 3'b010);
        push_bus(32'h404, 1'b0, '0, 4'hF, 3'b010);
        exp_rd_q.push_back(rd_pat(32'h400));
        exp_rd_q.push_back(rd_pat(32'h404));
        for (int i = 0; i < 4; i++) exp_rd_q.push_back('0);
        send_req(1'b0, 32'h400, 1'b1, 14'd6);
        n = 0;
        while (dbg_state_o != ST_ERR && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("err_cyc", 128'(cyc_o), 128'(0));
        check("err_flag", 128'(err_o), 128'(1));
        wait_done();
        check("err_sticky", 128'(err_o), 128'(1));
        err_at = 0;
        push_bus(32'h500, 1'b0, '0, 4'hF, 3'b111);
        exp_rd_q.push_back(rd_pat(32'h500));
        send_req(1'b0, 32'h500, 1'b0, 14'd0);
        check("err_cleared", 128'(err_o), 128'(0));
        wait_done();

        // reset in the middle of a burst write
        push_bus(32'h600, 1'b1, 32'h5555_0001, 4'hF, 3'b010);
        send_req(1'b1, 32'h600, 1'b1, 14'd4);
        send_write(32'h5555_0001, 4'b0000, 0);
        n = 0;
        while (exp_bus_q.size() != 0 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        ack_en = 1'b0;
        send_write(32'h5555_0002, 4'b0000, 0);
        check("pre_rst_cyc", 128'(cyc_o), 128'(1));
        rst_ni = 1'b0;
        #1;
        check("async_rst_cyc", 128'(cyc_o), 128'(0));
        check("async_rst_stb", 128'(stb_o), 128'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        ack_en = 1'b1;
        repeat (2) @(negedge clk_i);
        check("post_rst_req_ready", 128'(req_ready), 128'(1));
        push_bus(32'h700, 1'b0, '0, 4'hF, 3'b111);
        exp_rd_q.push_back(rd_pat(32'h700));
        send_req(1'b0, 32'h700, 1'b0, 14'd0);
        wait_done();

        check("bus_queue_empty", 128'(exp_bus_q.size()), 128'(0));
        check("rd_queue_empty", 128'(exp_rd_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
